// File: rtl/mux21_stim_seq_pkg.sv
// Shared definitions for the mux21 stimulus sequencer: FSM encoding and
// default toggle periods / sequence length.
package mux21_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_CNT_W   = 8;
  localparam int DEF_DIV_S   = 10;
  localparam int DEF_DIV_I1  = 20;
  localparam int DEF_DIV_I0  = 40;
  localparam int DEF_RUN_LEN = 100;
  localparam int DEF_ERR_W   = 8;

endpackage

// File: rtl/mux21_stim_seq_div_toggle.sv
// Divide-by-DIV toggle: while enabled, counts 0..DIV-1 and flips q on each
// wrap, so q during enabled cycle n equals floor(n/DIV) mod 2.
// clr has priority over en and returns both counter and q to zero.
module div_toggle #(
  parameter int DIV   = 10,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic q
);

  logic [CNT_W-1:0] cnt;

  // Period counter and output toggle flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (en) begin
      if (cnt == CNT_W'(DIV - 1)) begin
        cnt <= '0;
        q   <= ~q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux21_stim_seq.sv
// Clocked stimulus sequencer and checker for a 2:1 mux.
// Drives I[1:0] and s with independent toggle periods for RUN_LEN cycles
// and counts cycles where mux_out differs from s ? I[1] : I[0].
//
// Handshake: start is a one-cycle request, accepted only in IDLE (ignored
// in RUN and DONE). busy is high for exactly RUN_LEN cycles starting the
// cycle after acceptance; done is a one-cycle pulse the cycle after busy
// falls. err_cnt/err_flag hold their value until the next accepted start.
module mux21_stim_seq
  import mux21_stim_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DIV_S   = DEF_DIV_S,
  parameter int DIV_I1  = DEF_DIV_I1,
  parameter int DIV_I0  = DEF_DIV_I0,
  parameter int RUN_LEN = DEF_RUN_LEN,
  parameter int ERR_W   = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mux_out,
  output logic [1:0]       I,
  output logic             s,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_flag
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] t;
  logic [ERR_W-1:0] err_nxt;
  logic             accept;
  logic             last;
  logic             clr;
  logic             en;
  logic             expected;
  logic             q_s;
  logic             q_i1;
  logic             q_i0;

  assign accept = (state == ST_IDLE) && start;
  assign last   = (state == ST_RUN) && (t == CNT_W'(RUN_LEN - 1));
  // Clearing on the last RUN edge also returns I and s to 0 in DONE.
  assign clr    = accept || last;
  assign en     = (state == ST_RUN);

  assign I    = {q_i1, q_i0};
  assign s    = q_s;
  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  // Golden mux model on the stimulus held during the current cycle.
  assign expected = q_s ? q_i1 : q_i0;

  div_toggle #(.DIV(DIV_S),  .CNT_W(CNT_W)) u_div_s  (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .q(q_s)
  );
  div_toggle #(.DIV(DIV_I1), .CNT_W(CNT_W)) u_div_i1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .q(q_i1)
  );
  div_toggle #(.DIV(DIV_I0), .CNT_W(CNT_W)) u_div_i0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .q(q_i0)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after RUN_LEN
  // cycles, DONE -> IDLE after one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // RUN cycle counter t.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    t <= '0;
    else if (clr)  t <= '0;
    else if (en)   t <= t + 1'b1;
  end

  // Next mismatch count: cleared on accept, saturating increment in RUN.
  always_comb begin
    err_nxt = err_cnt;
    if (accept) begin
      err_nxt = '0;
    end else if (en && (mux_out != expected) && (err_cnt != {ERR_W{1'b1}})) begin
      err_nxt = err_cnt + 1'b1;
    end
  end

  // Mismatch counter and flag update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else begin
      err_cnt  <= err_nxt;
      err_flag <= (err_nxt != '0);
    end
  end

endmodule
